// File: rtl/transpose_pingpong.sv
// rtl/transpose_pingpong.sv - double-buffered NxN block transpose between AXI-Stream ports
module transpose_pingpong #(
   parameter int VALUE_WIDTH     = 17,
   parameter int AXIS_DATA_WIDTH = 8*((VALUE_WIDTH-1)/8+1),
   parameter int N               = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_mode,
   input  logic                       i_axis_TVALID,
   output logic                       o_axis_TREADY,
   input  logic [AXIS_DATA_WIDTH-1:0] i_axis_TDATA,
   input  logic                       i_axis_TLAST,
   output logic                       o_axis_TVALID,
   input  logic                       i_axis_TREADY,
   output logic [AXIS_DATA_WIDTH-1:0] o_axis_TDATA,
   output logic                       o_axis_TLAST,
   output logic                       o_err_tlast
);

   localparam int LOG2N = $clog2(N);
   localparam int CW    = 2*LOG2N;
   // N is a power of two, so the last beat index N*N-1 is all ones.
   localparam logic [CW-1:0] LAST_CNT = '1;

   // Bank b occupies addresses {b, offset}.
   logic [VALUE_WIDTH-1:0] mem [0:2*N*N-1];

   logic                       wr_bank;
   logic                       rd_bank;
   logic [CW-1:0]              wr_cnt;
   logic [CW-1:0]              rd_cnt;
   logic [1:0]                 full;
   logic [1:0]                 mode_bit;

   logic                       wr_acc;
   logic                       wr_done;
   logic                       rd_issue;
   logic                       rd_done;
   logic [CW-1:0]              rd_addr;

   logic                       s1_valid;
   logic                       s1_last;
   logic [VALUE_WIDTH-1:0]     s1_data;
   logic [AXIS_DATA_WIDTH-1:0] s1_ext;
   logic                       out_free;
   logic                       s1_free;

   generate
      if (AXIS_DATA_WIDTH > VALUE_WIDTH) begin : g_pad
         logic unused_tdata_pad;
         assign unused_tdata_pad = ^i_axis_TDATA[AXIS_DATA_WIDTH-1:VALUE_WIDTH];
      end
   endgenerate

   assign o_axis_TREADY = !i_reset && !full[wr_bank];
   assign wr_acc        = i_axis_TVALID && o_axis_TREADY;
   assign wr_done       = wr_acc && (wr_cnt == LAST_CNT);

   // Two-stage read pipeline: memory fetch register, then output register.
   // Each stage advances whenever the stage after it is empty or draining.
   assign out_free = !o_axis_TVALID || i_axis_TREADY;
   assign s1_free  = !s1_valid || out_free;
   assign rd_issue = full[rd_bank] && s1_free;
   // The bank is released as soon as its last word is fetched; the remaining
   // beats live in the pipeline registers, so the next block reads without a gap.
   assign rd_done  = rd_issue && (rd_cnt == LAST_CNT);

   // Transpose swaps row and column fields of the counter: (cnt mod N)*N + cnt/N.
   assign rd_addr = mode_bit[rd_bank] ? rd_cnt
                                      : {rd_cnt[LOG2N-1:0], rd_cnt[CW-1:LOG2N]};

   assign s1_ext = AXIS_DATA_WIDTH'($signed(s1_data));

   // Sample storage, written only by accepted input beats.
   always_ff @(posedge i_clk) begin
      if (wr_acc)
         mem[{wr_bank, wr_cnt}] <= i_axis_TDATA[VALUE_WIDTH-1:0];
   end

   // Write-side counter, bank pointer, per-bank mode capture and TLAST check.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_bank     <= 1'b0;
         wr_cnt      <= '0;
         mode_bit    <= 2'b00;
         o_err_tlast <= 1'b0;
      end else begin
         o_err_tlast <= wr_acc && (i_axis_TLAST != (wr_cnt == LAST_CNT));
         if (wr_acc) begin
            if (wr_cnt == '0)
               mode_bit[wr_bank] <= i_mode;
            if (wr_done) begin
               wr_cnt  <= '0;
               wr_bank <= !wr_bank;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end
      end
   end

   // Bank full flags: set on write completion, cleared on read release.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         full <= 2'b00;
      end else begin
         if (wr_done && !wr_bank)
            full[0] <= 1'b1;
         else if (rd_done && !rd_bank)
            full[0] <= 1'b0;
         if (wr_done && wr_bank)
            full[1] <= 1'b1;
         else if (rd_done && rd_bank)
            full[1] <= 1'b0;
      end
   end

   // Read-side counter, bank pointer and the fetch/output pipeline registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rd_bank       <= 1'b0;
         rd_cnt        <= '0;
         s1_valid      <= 1'b0;
         s1_last       <= 1'b0;
         s1_data       <= '0;
         o_axis_TVALID <= 1'b0;
         o_axis_TDATA  <= '0;
         o_axis_TLAST  <= 1'b0;
      end else begin
         if (out_free) begin
            o_axis_TVALID <= s1_valid;
            if (s1_valid) begin
               o_axis_TDATA <= s1_ext;
               o_axis_TLAST <= s1_last;
            end
         end
         if (s1_free) begin
            s1_valid <= rd_issue;
            if (rd_issue) begin
               s1_data <= mem[{rd_bank, rd_addr}];
               s1_last <= (rd_cnt == LAST_CNT);
            end
         end
         if (rd_issue) begin
            if (rd_done) begin
               rd_cnt  <= '0;
               rd_bank <= !rd_bank;
            end else begin
               rd_cnt <= rd_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_transpose_pingpong.sv
// tb/tb_transpose_pingpong.sv - directed self-checking bench for transpose_pingpong
module tb_transpose_pingpong;

   localparam int VW = 17;
   localparam int AW = 24;
   localparam int N  = 8;
   localparam int NN = N*N;

   logic          clk = 1'b0;
   logic          rst;
   logic          mode;
   logic          itv;
   logic          itl;
   logic [AW-1:0] itd;
   logic          ds_rdy;
   logic          otr;
   logic          otv;
   logic          otl;
   logic          err;
   logic [AW-1:0] otd;

   transpose_pingpong #(.VALUE_WIDTH(VW), .AXIS_DATA_WIDTH(AW), .N(N)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_mode        (mode),
      .i_axis_TVALID (itv),
      .o_axis_TREADY (otr),
      .i_axis_TDATA  (itd),
      .i_axis_TLAST  (itl),
      .o_axis_TVALID (otv),
      .i_axis_TREADY (ds_rdy),
      .o_axis_TDATA  (otd),
      .o_axis_TLAST  (otl),
      .o_err_tlast   (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] d;
      logic          l;
      logic          m;
   } beat_t;

   typedef struct packed {
      logic [AW-1:0] d;
      logic          l;
   } exp_t;

   beat_t in_q[$];
   exp_t  exp_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int pos = 0;
   int rdy_pat = 0;
   int tready_drops = 0;
   int err_pulses = 0;
   int first_out = -1;
   int last_out = -1;
   int first_valid = -1;
   int last_in_edge = -1;
   logic          err_pend = 1'b0;
   logic          stall_prev = 1'b0;
   logic [AW-1:0] stall_d = '0;
   logic          stall_l = 1'b0;
   logic [AW-1:0] junk = {7'h2A, {VW{1'b0}}};

   task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [AW-1:0] sx(input int v);
      return AW'(v);
   endfunction

   // Queue one block of values base + step*i; expected order follows the mode.
   task automatic add_block(input int base, input int step, input logic m, input logic bad_last);
      beat_t b;
      exp_t  e;
      int    idx;
      for (int i = 0; i < NN; i++) begin
         b.d = sx(base + step*i);
         b.l = bad_last ? (i == 9) : (i == NN-1);
         b.m = m;
         in_q.push_back(b);
      end
      for (int k = 0; k < NN; k++) begin
         idx = m ? k : (k % N)*N + k/N;
         e.d = sx(base + step*idx);
         e.l = (k == NN-1);
         exp_q.push_back(e);
      end
   endtask

   task automatic run(input int stop, input int budget);
      int   outs = 0;
      int   t = 0;
      logic in_acc;
      logic out_acc;
      exp_t e;
      while ((in_q.size() > 0 || exp_q.size() > 0) && t < budget && !(stop >= 0 && outs >= stop)) begin
         @(negedge clk);
         ds_rdy = (rdy_pat == 0) ? 1'b1 : (cyc % 3 == 0);
         if (in_q.size() > 0) begin
            itv  = 1'b1;
            itd  = in_q[0].d ^ junk;
            itl  = in_q[0].l;
            mode = in_q[0].m;
         end else begin
            itv = 1'b0;
            itd = '0;
            itl = 1'b0;
         end
         #1;
         check("err_tlast", AW'(err), AW'(err_pend));
         if (err) err_pulses++;
         if (stall_prev) begin
            check("stall_valid", AW'(otv), AW'(1));
            check("stall_data", otd, stall_d);
            check("stall_last", AW'(otl), AW'(stall_l));
         end
         if (otv && first_valid < 0) first_valid = cyc;
         if (itv && !otr) tready_drops++;
         in_acc  = itv && otr;
         out_acc = otv && ds_rdy;
         if (out_acc) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", AW'(otv), AW'(0));
            end else begin
               e = exp_q.pop_front();
               check("data", otd, e.d);
               check("last", AW'(otl), AW'(e.l));
            end
            outs++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
         end
         stall_prev = otv && !ds_rdy;
         stall_d    = otd;
         stall_l    = otl;
         err_pend   = in_acc && (itl != (pos == NN-1));
         if (in_acc) begin
            void'(in_q.pop_front());
            if (pos == NN-1) begin
               pos = 0;
               last_in_edge = cyc + 1;
            end else begin
               pos++;
            end
         end
         @(posedge clk);
         cyc++;
         t++;
      end
      n_cmp++;
      assert (t < budget) else begin
         n_err++;
         $error("FAIL timeout: observed %0d cycles budget %0d", t, budget);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      itv = 1'b0;
      itl = 1'b0;
      itd = '0;
      #1;
      check("rst_tready_now", AW'(otr), AW'(0));
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #1;
      check("rst_tvalid", AW'(otv), AW'(0));
      check("rst_tdata", otd, AW'(0));
      check("rst_tlast", AW'(otl), AW'(0));
      check("rst_err", AW'(err), AW'(0));
      check("rst_tready", AW'(otr), AW'(0));
      rst = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #1;
      check("post_rst_tready", AW'(otr), AW'(1));
      in_q.delete();
      exp_q.delete();
      pos        = 0;
      err_pend   = 1'b0;
      stall_prev = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      mode   = 1'b0;
      itv    = 1'b0;
      itl    = 1'b0;
      itd    = '0;
      ds_rdy = 1'b1;
      repeat (2) @(posedge clk);
      do_reset();

      // Basic transpose with latency measurement.
      first_valid = -1;
      err_pulses  = 0;
      add_block(1, 1, 1'b0, 1'b0);
      run(-1, 500);
      check("latency", AW'(first_valid - last_in_edge), AW'(2));
      check("no_err_pulses", AW'(err_pulses), AW'(0));

      // Negative values, sign extension.
      add_block(-1, -1, 1'b0, 1'b0);
      check("neg_first_exp", exp_q[0].d, 24'hFFFFFF);
      run(-1, 500);

      // Two back-to-back blocks: no input stall, contiguous output.
      tready_drops = 0;
      first_out    = -1;
      add_block(1, 1, 1'b0, 1'b0);
      add_block(65, 1, 1'b0, 1'b0);
      run(-1, 1000);
      check("b2b_tready_drops", AW'(tready_drops), AW'(0));
      check("b2b_contiguous", AW'(last_out - first_out), AW'(2*NN-1));

      // Three blocks with downstream ready 1-in-3.
      rdy_pat      = 1;
      tready_drops = 0;
      add_block(1, 1, 1'b0, 1'b0);
      add_block(65, 1, 1'b0, 1'b0);
      add_block(129, 1, 1'b0, 1'b0);
      run(-1, 2000);
      check("throttle_tready_low", AW'(tready_drops > 0), AW'(1));
      rdy_pat = 0;

      // Pass-through block followed by a transposed block.
      add_block(1, 1, 1'b1, 1'b0);
      add_block(1, 1, 1'b0, 1'b0);
      run(-1, 1000);

      // Misplaced TLAST: two error pulses, data unaffected.
      err_pulses = 0;
      add_block(1, 1, 1'b0, 1'b1);
      run(-1, 500);
      check("tlast_err_pulses", AW'(err_pulses), AW'(2));

      // Reset in the middle of output, then a fresh block.
      add_block(1, 1, 1'b0, 1'b0);
      run(20, 500);
      do_reset();
      add_block(1, 1, 1'b0, 1'b0);
      run(-1, 500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/transpose_pingpong.md
# transpose_pingpong

Parametrised N×N matrix transpose on AXI-Stream, double-buffered so block k+1 is written while block k is read out. It accepts signed VALUE_WIDTH-bit samples in raster order and emits each block column-major, or unchanged when in pass-through mode. It sits between row-pass and column-pass stages of the 2-D DCT/IDCT datapath in the H.263 pipeline. Compared with the single-buffer 8×8 transpose, it adds block-size generality, sustained 1 beat/cycle throughput, per-block mode, output TLAST generation and TLAST checking.

## Interface
- VALUE_WIDTH, 17, signed sample width.
- AXIS_DATA_WIDTH, 8*((VALUE_WIDTH-1)/8+1), TDATA width, byte-rounded.
- N, 8, block dimension; power of two, 2..32.
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_mode  in  1  0 = transpose, 1 = pass-through; sampled with the first beat of each block.
- i_axis_TVALID  in  1  input beat valid.
- o_axis_TREADY  out  1  input beat accepted when TVALID && TREADY.
- i_axis_TDATA  in  AXIS_DATA_WIDTH  sample in bits [VALUE_WIDTH-1:0]; upper bits ignored.
- i_axis_TLAST  in  1  expected high on beat N*N of each block.
- o_axis_TVALID  out  1  output beat valid.
- i_axis_TREADY  in  1  downstream ready.
- o_axis_TDATA  out  AXIS_DATA_WIDTH  sample, sign-extended from bit VALUE_WIDTH-1.
- o_axis_TLAST  out  1  high on the last beat (N*N) of each output block.
- o_err_tlast  out  1  one-cycle pulse on input TLAST mismatch.

## Operation
- Two banks, B0 and B1, each N*N×VALUE_WIDTH. Each bank has a full flag and a mode bit.
- Write side:
  - wr_bank starts at B0; wr_cnt runs 0..N*N-1.
  - An accepted beat writes address wr_cnt and increments wr_cnt.
  - On beat wr_cnt==0, i_mode is stored in that bank's mode bit.
  - On beat N*N-1: set the bank's full flag, clear wr_cnt, toggle wr_bank.
- o_axis_TREADY = !reset && !full[wr_bank]. It deasserts only when both banks are full.
- Read side:
  - rd_bank starts at B0; rd_cnt runs 0..N*N-1 and starts once full[rd_bank] is set.
  - Transpose mode: read address = (rd_cnt mod N)*N + rd_cnt/N, so output (r,c) = input (c,r).
  - Pass-through mode: read address = rd_cnt.
  - When the output beat with rd_cnt==N*N-1 is accepted: clear full[rd_bank], toggle rd_bank, clear rd_cnt.
- TLAST check:
  - o_err_tlast pulses the cycle after an accepted beat where i_axis_TLAST != (wr_cnt==N*N-1).
  - Block framing always follows wr_cnt; TLAST never truncates or extends a block.
- Data is stored verbatim; no arithmetic. Output bits above VALUE_WIDTH-1 replicate the sign bit.
- Simultaneous events:
  - A write-bank completion and a read-bank release on the same edge both take effect.
  - If the released bank is the next write bank, TREADY rises the following cycle.
  - Same-bank write and read cannot occur, because a bank is read only while full.

## Timing
- Reset values: o_axis_TVALID=0, o_axis_TDATA=0, o_axis_TLAST=0, o_err_tlast=0, o_axis_TREADY=0 during reset. Both full flags, wr_cnt, rd_cnt, wr_bank and rd_bank are cleared.
- o_axis_TREADY is 1 in the first cycle after reset deasserts.
- Latency: if the last input beat of a block is accepted at edge E and the read side is idle, the first output beat is valid from edge E+2.
- Throughput: 1 beat/cycle on both ports when downstream TREADY is held high. Back-to-back blocks produce no bubbles after the first block's latency.
- Output handshake:
  - While o_axis_TVALID && !i_axis_TREADY, TDATA and TLAST are held stable.
  - o_axis_TVALID never drops without a transfer, except on reset.
  - The memory read pipeline is stalled or skid-buffered accordingly.
- Reset mid-block (input or output side): the next cycle has TVALID=0, and all partial data is discarded. The first block after reset behaves as from power-up.

## Test plan
- N=8, mode 0, input 1..64 with TLAST on beat 64, TREADY held 1 -> output 1,9,17,…,57,2,10,…,64. TLAST on output 64 only; o_err_tlast never pulses.
- VALUE_WIDTH=17, input -1..-64 -> output -1,-9,…,-57,-2,…,-64. o_axis_TDATA=24'hFFFFFF for -1 (sign-extended).
- Two blocks back-to-back (1..64, then 65..128) -> o_axis_TREADY stays 1 for all 128 input beats. 128 contiguous output beats; second block starts 65,73,….
- Downstream TREADY toggled 1-in-3, three blocks sent continuously -> o_axis_TREADY low while both banks are full. All 192 outputs correct in order; TDATA stable during stalls.
- Block 1 with i_mode=1 (values 1..64), block 2 with i_mode=0 -> block 1 emerges 1,2,…,64, block 2 is transposed.
- i_axis_TLAST asserted on beat 10 and absent on beat 64 -> two o_err_tlast pulses and the output is still correct. Then i_reset asserted at output beat 20 -> TVALID=0 the next cycle, and a fresh 1..64 block transposes correctly.
